// File: rtl/multiplier_4_bit_seq_pkg.sv
// Shared types and sizing for the sequential 4x4 shift-and-add multiplier.
package mul_seq_pkg;
    localparam int WIDTH      = 4;
    localparam int ITERS      = 4;
    localparam int PROD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/multiplier_4_bit_seq_if.sv
// Operand and product handshakes between a producer/consumer (master) and the multiplier (slave).
interface multiplier_4_bit_seq_if;
    import mul_seq_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  out_valid;
    logic                  out_ready;
    logic [PROD_WIDTH-1:0] product;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/ripple_carry_adder_4_bit.sv
// 4-bit ripple-carry adder: one full-adder stage per bit, carry chained LSB to MSB.
module ripple_carry_adder_4_bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);
    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = carry_in;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        carry_out = carry[4];
    end
endmodule

// File: rtl/multiplier_4_bit_seq.sv
// Sequential 4x4 unsigned multiplier: one ripple add plus a 9-bit right shift per cycle,
// four iterations, product held in {acc, mq} until the consumer takes it.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// RUN   | one add/shift iteration per cycle, count tracks iterations 0..3
// DONE  | out_valid high, product held until out_ready
module multiplier_4_bit_seq
    import mul_seq_pkg::*;
(
    input logic                   clk,
    input logic                   reset,
    multiplier_4_bit_seq_if.slave bus
);
    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic [1:0]       count;
    logic             last_iter;
    logic             in_ready;
    logic             out_valid;

    assign add_b     = mq[0] ? mcand : '0;
    assign last_iter = (count == 2'(ITERS - 1));

    ripple_carry_adder_4_bit u_adder (
        .a         (acc),
        .b         (add_b),
        .carry_in  (1'b0),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) next_state = RUN;
            end
            RUN: begin
                if (last_iter) next_state = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The adder carry lands in acc[3]; the bit shifted out of sum enters mq from the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            mq    <= '0;
            acc   <= '0;
            count <= '0;
        end else if (state == IDLE && bus.in_valid) begin
            mcand <= bus.a;
            mq    <= bus.b;
            acc   <= '0;
            count <= '0;
        end else if (state == RUN) begin
            acc <= {carry_out, sum[WIDTH-1:1]};
            mq  <= {sum[0], mq[WIDTH-1:1]};
            if (!last_iter) count <= count + 2'd1;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.product   = {acc, mq};
endmodule
